// File: rtl/crypto_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared crypto datapath.
// A grant is held from the first beat to tlast; crypt_en is latched per packet at grant time.
module crypto_input_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 4,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                                       axi_aclk,
  input  logic                                       axi_aresetn,
  input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_QUEUES*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                       s_axis_tvalid,
  output logic [NUM_QUEUES-1:0]                       s_axis_tready,
  input  logic [NUM_QUEUES-1:0]                       s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,
  output logic                                        crypt_en,
  input  logic [NUM_QUEUES-1:0]                       port_enable,
  input  logic [NUM_QUEUES-1:0]                       crypt_mask,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]             pkt_count
);

  localparam int GW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        gnt_q, gnt_d;
  logic [GW-1:0]        last_gnt_q, last_gnt_d;
  logic                 crypt_en_q, crypt_en_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q [NUM_QUEUES];
  logic [CNT_WIDTH-1:0] pkt_cnt_d [NUM_QUEUES];

  logic [NUM_QUEUES-1:0] cand_s;
  logic                  found_s;
  logic                  hit_s;
  logic [GW-1:0]         win_s;
  logic [GW-1:0]         sel_s;
  logic                  eop_s;
  int                    idx_s;

  // Round-robin search starting just after the last port that completed a packet
  always_comb begin
    cand_s  = s_axis_tvalid & port_enable;
    found_s = 1'b0;
    hit_s   = 1'b0;
    win_s   = '0;
    idx_s   = 0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      idx_s   = (int'(last_gnt_q) + k) % NUM_QUEUES;
      hit_s   = !found_s && cand_s[idx_s];
      win_s   = hit_s ? GW'(idx_s) : win_s;
      found_s = found_s | hit_s;
    end
  end

  assign eop_s = (state_q == SEND) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    crypt_en_d = crypt_en_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d    = SEND;
          gnt_d      = win_s;
          crypt_en_d = crypt_mask[win_s];
        end else begin
          state_d    = IDLE;
        end
      end
      SEND: begin
        if (eop_s) begin
          state_d    = IDLE;
          last_gnt_d = gnt_q;
        end else begin
          state_d    = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Per-port completed-packet counters wrap naturally at all-ones
  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      pkt_cnt_d[i] = pkt_cnt_q[i];
    end
    if (eop_s) begin
      pkt_cnt_d[gnt_q] = pkt_cnt_q[gnt_q] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      pkt_cnt_d[gnt_q] = pkt_cnt_q[gnt_q];
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_gnt_q <= GW'(NUM_QUEUES - 1);
      crypt_en_q <= 1'b0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        pkt_cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      crypt_en_q <= crypt_en_d;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        pkt_cnt_q[i] <= pkt_cnt_d[i];
      end
    end
  end

  // Zero-latency mux; idle selects slice 0 with valid/ready forced low
  always_comb begin
    sel_s         = (state_q == SEND) ? gnt_q : '0;
    m_axis_tdata  = s_axis_tdata[int'(sel_s)*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
    m_axis_tstrb  = s_axis_tstrb[int'(sel_s)*SW +: SW];
    m_axis_tuser  = s_axis_tuser[int'(sel_s)*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
    m_axis_tlast  = s_axis_tlast[sel_s];
    crypt_en      = crypt_en_q;
    s_axis_tready = '0;
    if (state_q == SEND) begin
      m_axis_tvalid        = s_axis_tvalid[gnt_q];
      s_axis_tready[gnt_q] = m_axis_tready;
    end else begin
      m_axis_tvalid        = 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt_out
    assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[g];
  end

endmodule

// File: doc/crypto_input_arbiter.md
Name: crypto_input_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single crypto datapath between NUM_QUEUES upstream AXI4-Stream sources.
- Grant is held from the first beat to tlast, so the downstream header/payload state tracking never sees interleaved packets.
- Drives a per-packet crypt_en sideband from a configuration mask, telling the crypto stage whether to transform or bypass the packet.
- Keeps a free-running per-port packet counter for the register block.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master tdata width
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width per port; must equal C_M_AXIS_DATA_WIDTH
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width per port; must equal C_M_AXIS_TUSER_WIDTH
- NUM_QUEUES, 4, number of slave ports (2..8)
- CNT_WIDTH, 32, width of each packet counter

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  NUM_QUEUES*C_S_AXIS_DATA_WIDTH  per-port data; port i occupies slice i
- s_axis_tstrb  in  NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8  per-port byte strobes
- s_axis_tuser  in  NUM_QUEUES*C_S_AXIS_TUSER_WIDTH  per-port tuser
- s_axis_tvalid  in  NUM_QUEUES  per-port valid
- s_axis_tready  out  NUM_QUEUES  per-port ready
- s_axis_tlast  in  NUM_QUEUES  per-port last
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  to crypto stage
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- crypt_en  out  1  valid alongside m_axis beats; 1 means encrypt this packet
- port_enable  in  NUM_QUEUES  config: port i may be granted only if bit i is set
- crypt_mask  in  NUM_QUEUES  config: packets from port i have crypt_en equal to bit i
- pkt_count  out  NUM_QUEUES*CNT_WIDTH  per-port count of completed packets

Behaviour:
- State machine, two states:
  - IDLE: no grant held.
  - SEND: grant register gnt (log2 NUM_QUEUES bits) owns the output.
- Reset (asynchronous, axi_aresetn low):
  - state=IDLE, gnt=0, last_gnt=NUM_QUEUES-1 (so port 0 has first priority), crypt_en register=0, all pkt_count=0.
  - Outputs during reset: m_axis_tvalid=0, s_axis_tready=0.
- IDLE arbitration:
  - Candidates are ports with s_axis_tvalid[i] & port_enable[i].
  - Search from last_gnt+1 upward, modulo NUM_QUEUES; the first candidate wins.
  - On the clock edge: gnt=winner, state=SEND, crypt_en register=crypt_mask[winner].
  - No candidates: stay in IDLE.
- Latency: one bubble cycle per packet. The first beat is transferred no earlier than the cycle after the grant.
- SEND datapath (combinational, zero latency):
  - m_axis_tdata, tstrb, tuser, tlast, tvalid = slice gnt of the corresponding s_axis bus.
  - s_axis_tready[gnt] = m_axis_tready; all other tready bits are 0.
  - No registers in the data path.
- End of packet: a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast does the following on that edge:
  - state=IDLE, last_gnt=gnt;
  - pkt_count[gnt] increments, wrapping from all-ones to 0.
- IDLE outputs: m_axis_tvalid=0, s_axis_tready=0, m_axis data outputs = slice 0 (don't care).
- crypt_en is the registered value captured at grant. Changes to crypt_mask or port_enable mid-packet do not affect the packet in flight.
- Clearing port_enable for the granted port mid-packet does not abort the packet; the grant is still held to tlast.
- Single-beat packet (tlast on the first beat): takes IDLE -> SEND -> IDLE. The port can be re-granted at the earliest 2 cycles after its grant, and only if no other candidate exists.
- Backpressure: m_axis_tready low holds all state. The source must hold its data stable per AXI4-Stream rules.
- Reset mid-packet: the packet is truncated downstream, with no tlast. The downstream block is reset from the same axi_aresetn.

Test Plan:
- Single source: port 2 sends a 3-beat packet, tdata=A,B,C, crypt_mask=4'b0100 -> 1 bubble cycle, then A,B,C on m_axis with crypt_en=1, tlast on C, pkt_count[2]=1.
- Round-robin fairness: all 4 ports continuously valid with 2-beat packets -> grant order 0,1,2,3,0; each packet contiguous; each pkt_count=1 after 4 packets.
- Backpressure: m_axis_tready toggles 1010 during a 4-beat packet from port 1 -> beats transferred only when ready=1, no beat lost or duplicated, s_axis_tready[1]==m_axis_tready and other tready bits 0 throughout.
- Enable and mask: port_enable=4'b1011 with port 2 valid -> port 2 never granted. Flip crypt_mask[0] mid-packet from port 0 -> crypt_en stays at its grant-time value until tlast.
- Reset mid-packet: assert axi_aresetn low on beat 2 of 5 -> m_axis_tvalid=0 immediately, pkt_count=0, and the first grant after release goes to port 0.
- Counter wrap: CNT_WIDTH=4, send 17 packets from port 3 -> pkt_count[3]=1.
